// File: rtl/mod4051_pkg.sv
// Shared constants and FSM state type for the sequential mod-4051 Horner reducer.
package mod4051_pkg;

    localparam int unsigned W_IN    = 400;
    localparam int unsigned LIMB    = 12;
    localparam int unsigned MOD     = 4051;
    localparam int unsigned K_FOLD  = 45;
    localparam int unsigned N_LIMBS = (W_IN + LIMB - 1) / LIMB;
    localparam int unsigned SR_W    = N_LIMBS * LIMB;
    localparam int unsigned CNT_W   = 6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/mod_4051_step.sv
// One Horner step: (acc*2^LIMB + limb) mod MOD, computed as acc*K_FOLD + limb then folded.
module mod_4051_step
    import mod4051_pkg::*;
(
    input  logic [LIMB:1] i_acc,
    input  logic [LIMB:1] i_limb,
    output logic [LIMB:1] o_acc_next
);

    localparam int unsigned T1_W = 18;
    localparam int unsigned T2_W = LIMB + 1;

    logic [T1_W:1] w_t1;
    logic [T2_W:1] w_t2;
    logic [T2_W:1] w_t3;

    // Each fold replaces the bits above LIMB by their weight times K_FOLD.
    assign w_t1 = T1_W'(i_acc) * T1_W'(K_FOLD) + T1_W'(i_limb);
    assign w_t2 = T2_W'(w_t1[LIMB:1]) + T2_W'(w_t1[T1_W:LIMB+1]) * T2_W'(K_FOLD);
    assign w_t3 = T2_W'(w_t2[LIMB:1]) + (w_t2[T2_W] ? T2_W'(K_FOLD) : '0);

    always_comb begin
        o_acc_next = w_t3[LIMB:1];
        if (w_t3 >= T2_W'(MOD)) begin
            o_acc_next = LIMB'(w_t3 - T2_W'(MOD));
        end
    end

endmodule

// File: rtl/mod_4051_horner_seq.sv
// Sequential mod-4051 reducer: walks a 400-bit operand MSB-first, one 12-bit limb per cycle.
module mod_4051_horner_seq
    import mod4051_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [W_IN:1] i_x,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [LIMB:1] o_r,
    output logic          o_busy
);

    state_e           r_state;
    state_e           w_state_d;
    logic [SR_W:1]    r_sr;
    logic [SR_W:1]    w_sr_d;
    logic [LIMB:1]    r_acc;
    logic [LIMB:1]    w_acc_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [LIMB:1]    w_acc_step;

    mod_4051_step u_step (
        .i_acc      (r_acc),
        .i_limb     (r_sr[SR_W:SR_W-LIMB+1]),
        .o_acc_next (w_acc_step)
    );

    always_comb begin
        w_state_d = r_state;
        w_sr_d    = r_sr;
        w_acc_d   = r_acc;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (i_in_valid) begin
                    // Top limb is zero-extended by the width cast.
                    w_sr_d    = SR_W'(i_x);
                    w_acc_d   = '0;
                    w_cnt_d   = CNT_W'(N_LIMBS - 1);
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_acc_d = w_acc_step;
                w_sr_d  = r_sr << LIMB;
                w_cnt_d = r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                if (i_out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_sr    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_sr    <= w_sr_d;
            r_acc   <= w_acc_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign o_in_ready  = (r_state == StIdle);
    assign o_out_valid = (r_state == StDone);
    assign o_busy      = (r_state != StIdle);
    assign o_r         = r_acc;

endmodule

// File: tb/tb_mod_4051_horner_seq.sv
// Randomized self-checking bench for mod_4051_horner_seq against a plain X % 4051 model.
module tb_mod_4051_horner_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [400:1] x;
    logic         out_valid;
    logic         out_ready;
    logic [12:1]  r;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    mod_4051_horner_seq dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_x         (x),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_r         (r),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mod(input logic [400:1] v);
        logic [399:0] a;
        logic [399:0] m;
        a = v;
        m = a % 400'd4051;
        return 32'(m[11:0]);
    endfunction

    function automatic logic [400:1] rand_x();
        logic [415:0] t;
        for (int k = 0; k < 13; k++) t[k*32 +: 32] = $urandom;
        return t[399:0];
    endfunction

    // Accept x, wait for out_valid (bounded), return residue and latency, then drain.
    task automatic do_op(input logic [400:1] xv, output logic [31:0] res, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        x        = xv;
        @(negedge clk);
        in_valid = 1'b0;
        x        = rand_x();
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res       = 32'(r);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [400:1] dir_x   [8];
    logic [31:0]  dir_exp [8];
    logic [31:0]  res;
    logic [31:0]  held;
    int           lat;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        if (mod4051_pkg::K_FOLD != ((1 << mod4051_pkg::LIMB) % mod4051_pkg::MOD)) begin
            $display("FAIL k_fold: got %0d expected %0d", mod4051_pkg::K_FOLD,
                     (1 << mod4051_pkg::LIMB) % mod4051_pkg::MOD);
            $fatal(1, "K_FOLD inconsistent with MOD");
        end
        do_reset();

        check_eq("rst_in_ready", 32'(in_ready), 1);
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_r", 32'(r), 0);

        dir_x[0] = '0;              dir_exp[0] = 0;
        dir_x[1] = 400'd4051;       dir_exp[1] = 0;
        dir_x[2] = 400'd4050;       dir_exp[2] = 4050;
        dir_x[3] = 400'd4052;       dir_exp[3] = 1;
        dir_x[4] = 400'd1 << 12;    dir_exp[4] = 45;
        dir_x[5] = 400'd1 << 24;    dir_exp[5] = 2025;
        dir_x[6] = 400'd1 << 36;    dir_exp[6] = 2003;
        dir_x[7] = '1;              dir_exp[7] = ref_mod('1);
        for (int i = 0; i < 8; i++) begin
            do_op(dir_x[i], res, lat);
            check_eq($sformatf("dir_r_%0d", i), res, dir_exp[i]);
            check_eq($sformatf("dir_lat_%0d", i), 32'(lat), 35);
        end

        for (int i = 0; i < 1000; i++) begin
            logic [400:1] xv;
            xv = rand_x();
            if (i % 4 == 1) xv = xv & (rand_x() >> $urandom_range(399, 0));
            do_op(xv, res, lat);
            check_eq($sformatf("rnd_r_%0d", i), res, ref_mod(xv));
            if (i % 100 == 0) check_eq($sformatf("rnd_lat_%0d", i), 32'(lat), 35);
        end

        // Back-pressure in DONE with a competing in_valid.
        begin
            logic [400:1] xv;
            int guard;
            xv = rand_x();
            @(negedge clk);
            in_valid = 1'b1;
            x        = xv;
            @(negedge clk);
            in_valid = 1'b0;
            check_eq("run_busy", 32'(busy), 1);
            check_eq("run_in_ready", 32'(in_ready), 0);
            guard = 0;
            while (!out_valid && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check_eq("bp_reached_done", 32'(out_valid), 1);
            held = ref_mod(xv);
            in_valid = 1'b1;
            x        = rand_x();
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                check_eq("bp_r", 32'(r), held);
                check_eq("bp_out_valid", 32'(out_valid), 1);
                check_eq("bp_in_ready", 32'(in_ready), 0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_eq("bp_no_reaccept_ready", 32'(in_ready), 1);
            check_eq("bp_no_reaccept_busy", 32'(busy), 0);
            in_valid = 1'b0;
        end

        // Reset in RUN aborts the operation.
        @(negedge clk);
        in_valid = 1'b1;
        x        = rand_x();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rrun_in_ready", 32'(in_ready), 1);
        check_eq("rrun_out_valid", 32'(out_valid), 0);
        check_eq("rrun_r", 32'(r), 0);
        check_eq("rrun_busy", 32'(busy), 0);
        held = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) held = 1;
        end
        check_eq("rrun_no_pulse", held, 0);
        do_op(400'd4096, res, lat);
        check_eq("rrun_next_r", res, 45);
        check_eq("rrun_next_lat", 32'(lat), 35);

        // Reset in DONE, with out_ready high in the same cycle.
        @(negedge clk);
        in_valid = 1'b1;
        x        = 400'd4050;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (34) @(negedge clk);
        check_eq("rdone_valid", 32'(out_valid), 1);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        check_eq("rdone_out_valid", 32'(out_valid), 0);
        check_eq("rdone_r", 32'(r), 0);
        check_eq("rdone_in_ready", 32'(in_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
